// File: rtl/deskew_ctrl_rx.sv
// deskew_ctrl_rx: receive-side multi-lane deskew sequencer.
// Waits for AM lock on every lane, forwards the first AM per lane as the
// lane skew-counter reset, enforces the max-skew window and freezes the lane
// counters once all lanes are aligned. Reports done/error and latest lane.
// Optional build macro: DESKEW_ERR_CNT_EN adds an 8-bit saturating error
// counter on err_cnt_o.

// Per-lane first-AM filter: a lane forwards its AM only until it has been seen.
module deskew_lane (
  input  logic en,
  input  logic am_v,
  input  logic seen,
  output logic am_lite,
  output logic seen_nxt
);
  assign am_lite  = en & am_v & ~seen;
  assign seen_nxt = seen | am_v;
endmodule

module deskew_ctrl_rx #(
  parameter int LANE_N           = 4,
  parameter int MAX_SKEW_BLOCK_N = 27,
  parameter int CNT_W            = $clog2(MAX_SKEW_BLOCK_N+1),
  parameter int LANE_W           = $clog2(LANE_N)
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [LANE_N-1:0] am_lock_i,
  input  logic [LANE_N-1:0] am_v_i,
  input  logic [LANE_N-1:0] skew_zero_i,
  output logic [LANE_N-1:0] am_lite_v_o,
  output logic              am_lite_lock_full_v_o,
  output logic              deskew_done_o,
  output logic              deskew_err_o,
  output logic [LANE_W-1:0] lane_latest_o
`ifdef DESKEW_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, COLLECT, LOCKED, ERR} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_SKEW_BLOCK_N);

  state_t              state_q, state_d;
  logic [LANE_N-1:0]   seen_q, seen_nxt;
  logic [CNT_W-1:0]    cnt_q;
  logic [LANE_W-1:0]   lane_latest_q, latest_enc;
  logic                first_q;
  logic                lock_all, coll_en, all_seen, any_seen, timeout;

  assign lock_all = &am_lock_i;
  // Forwarding is suppressed on a lock-loss cycle even while in COLLECT.
  assign coll_en  = (state_q == COLLECT) && lock_all;
  assign all_seen = &seen_nxt;
  assign any_seen = |seen_nxt;
  // Window is open once any lane has been seen; cnt_q counts cycles since.
  assign timeout  = any_seen && (cnt_q == CNT_MAX);

  genvar l;
  generate
    for (l = 0; l < LANE_N; l++) begin : g_lane
      deskew_lane u_lane (
        .en      (coll_en),
        .am_v    (am_v_i[l]),
        .seen    (seen_q[l]),
        .am_lite (am_lite_v_o[l]),
        .seen_nxt(seen_nxt[l])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; lock loss beats all-seen, which beats timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (lock_all) state_d = COLLECT;
      COLLECT: begin
        if (!lock_all)     state_d = IDLE;
        else if (all_seen) state_d = LOCKED;
        else if (timeout)  state_d = ERR;
      end
      LOCKED:  if (!lock_all) state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    am_lite_lock_full_v_o = (state_q == LOCKED);
    deskew_done_o         = (state_q == LOCKED);
    deskew_err_o          = (state_q == ERR);
    lane_latest_o         = first_q ? latest_enc : lane_latest_q;
  end

  // Lowest lane whose skew counter reads zero is the latest-arriving lane.
  always_comb begin
    latest_enc = '0;
    for (int i = LANE_N-1; i >= 0; i--)
      if (skew_zero_i[i]) latest_enc = LANE_W'(i);
  end

  // Seen mask and saturating window counter; cleared outside a live round.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      seen_q <= '0;
      cnt_q  <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (lock_all) begin
            seen_q <= seen_nxt;
            if (!any_seen)           cnt_q <= '0;
            else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
          end else begin
            seen_q <= '0;
            cnt_q  <= '0;
          end
        end
        LOCKED: ;
        default: begin
          seen_q <= '0;
          cnt_q  <= '0;
        end
      endcase
    end
  end

  // Latest-lane capture on the first LOCKED cycle, held afterwards.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      first_q       <= 1'b0;
      lane_latest_q <= '0;
    end else begin
      first_q <= (state_q == COLLECT) && (state_d == LOCKED);
      if (first_q) lane_latest_q <= latest_enc;
    end
  end

`ifdef DESKEW_ERR_CNT_EN
  logic [7:0] err_cnt_q;
  logic       err_inc;
  assign err_inc   = (state_q == ERR) || ((state_q == LOCKED) && !lock_all);
  assign err_cnt_o = err_cnt_q;

  // Saturating count of window overruns and lock losses while aligned.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)                           err_cnt_q <= '0;
    else if (err_inc && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
  end
`endif

endmodule

// File: doc/deskew_ctrl_rx.md
Name: deskew_ctrl_rx

Overview:
- Receive-side deskew sequencer for the multi-lane PCS (e.g. 40GBASE-R, 4 lanes).
- Waits for alignment-marker lock on every lane, then opens one deskew round. It forwards only the first AM seen per lane to the per-lane deskew buffers as the skew-counter reset.
- Enforces the max-skew window and freezes all lane skew counters once every lane has seen its AM.
- Reports deskew done/error and the index of the latest (zero-skew) lane.

Parameters:
- LANE_N, 4, number of PCS lanes.
- MAX_SKEW_BLOCK_N, 27, maximum tolerated inter-lane skew in blocks; must match the lane buffer depth.
- CNT_W, $clog2(MAX_SKEW_BLOCK_N+1), window counter width.
- LANE_W, $clog2(LANE_N), lane index width.

Ports:
- clk  in  1  clock, one block per lane per cycle.
- nreset  in  1  asynchronous active-low reset.
- am_lock_i  in  LANE_N  per-lane alignment-marker lock, level.
- am_v_i  in  LANE_N  per-lane AM block present this cycle, pulse.
- skew_zero_i  in  LANE_N  per-lane "skew counter is zero" from the lane buffers.
- am_lite_v_o  out  LANE_N  per-lane skew reset pulse to the lane buffers.
- am_lite_lock_full_v_o  out  1  all lanes aligned; freezes the lane skew counters.
- deskew_done_o  out  1  level; equal to am_lite_lock_full_v_o.
- deskew_err_o  out  1  one-cycle pulse on window overrun.
- lane_latest_o  out  LANE_W  index of the latest lane, valid while deskew_done_o=1.

Behaviour:
- Reset (async assert, sync deassert internally not required): state=IDLE, seen_q=0, cnt_q=0, lane_latest_q=0. All outputs are 0.
- FSM has four states: IDLE, COLLECT, LOCKED, ERR.
- IDLE:
  - Go to COLLECT when &am_lock_i=1.
  - seen_q and cnt_q are cleared.
- COLLECT:
  - am_lite_v_o[l] = am_v_i[l] & ~seen_q[l]. This is combinational, same cycle, and only the first AM per lane is forwarded.
  - seen_next = seen_q | am_v_i.
  - The window opens at the first cycle with |seen_next=1 while seen_q=0 (call it cycle 0).
  - cnt_q increments every cycle after the window opens and saturates at MAX_SKEW_BLOCK_N.
  - If &seen_next=1, go to LOCKED next cycle. All lanes in the same cycle goes to LOCKED directly.
  - Otherwise, if the window is open and cnt_q==MAX_SKEW_BLOCK_N, go to ERR.
  - "All seen" has priority over timeout in the same cycle.
  - If ~&am_lock_i, go to IDLE; this has priority over all other transitions, and no am_lite_v_o pulse is produced that cycle.
- LOCKED:
  - am_lite_lock_full_v_o=1 and deskew_done_o=1, registered. They rise the cycle after the last lane's AM, so that lane's skew reads 0.
  - am_lite_v_o=0.
  - lane_latest_q is captured on the first LOCKED cycle as the lowest index l with skew_zero_i[l]=1, then held.
  - ~&am_lock_i sends the FSM to IDLE, and full drops the next cycle.
  - Further am_v_i are ignored.
- ERR:
  - Lasts exactly 1 cycle with deskew_err_o=1.
  - Clears seen_q and cnt_q, then goes to IDLE.
  - A retry from IDLE starts immediately if lock is still held.
- Window arithmetic: cnt_q is unsigned CNT_W bits and never wraps, because it saturates.
- A lane skew of exactly MAX_SKEW_BLOCK_N blocks is accepted. MAX_SKEW_BLOCK_N+1 blocks is an error.
- Reset asserted mid-round aborts immediately to the reset values.

Optional Feature:
- Macro: DESKEW_ERR_CNT_EN.
- Defined:
  - Adds output port err_cnt_o, 8 bits.
  - err_cnt_o is an 8-bit saturating count of ERR entries, reset to 0 only by nreset.
  - A lock loss in LOCKED also increments it.
  - It saturates at 255.
- Undefined: no port, no counter; the rest of the behaviour is identical.

Test Plan:
- LANE_N=4, all lock at t0; AMs on lanes 0,1,2,3 at cycles 10,12,15,20:
  - am_lite_v_o pulses once per lane at those cycles.
  - full=1 and done=1 from cycle 21.
  - lane_latest_o=3.
  - A repeat AM on lane 0 at cycle 14 produces no pulse.
- All four AMs at cycle 5 → LOCKED at cycle 6, lane_latest_o=0 (lowest index with skew zero).
- Lane 0 AM at cycle 0, lane 3 AM at cycle 27 (others earlier) → accepted, LOCKED at cycle 28.
- Same as above but lane 3 AM at cycle 28 → deskew_err_o pulse at cycle 28, state returns to IDLE, and a new round starts.
- In LOCKED, drop am_lock_i[2] for 1 cycle → full low the next cycle; the re-lock triggers a fresh COLLECT round.
- With DESKEW_ERR_CNT_EN: force 300 window overruns → err_cnt_o reaches and holds 255. Assert nreset → err_cnt_o=0 asynchronously.
